// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and board timing constants for the button front end
//   CLK_HZ          board clock frequency used to derive the default cycle counts
//   ST_*            state encodings for the press/hold tracker
//   state_t         enumerated state type built on those encodings
package button_pkg;

    localparam int CLK_HZ = 50_000_000;

    // Default timings: 20 ms debounce, 1 s long press, 5 repeats per second.
    localparam int DEF_DB_CYCLES     = CLK_HZ / 50;
    localparam int DEF_LONG_CYCLES   = CLK_HZ;
    localparam int DEF_REPEAT_CYCLES = CLK_HZ / 5;

    localparam logic [1:0] ST_RELEASED = 2'd0;
    localparam logic [1:0] ST_PRESSED  = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    typedef enum logic [1:0] {
        RELEASED = ST_RELEASED,
        PRESSED  = ST_PRESSED,
        HELD     = ST_HELD
    } state_t;

endpackage

// File: rtl/btn_synchronizer.sv
// btn_synchronizer: multi-flop synchronizer bringing an asynchronous level into the clk domain
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset, clears the whole chain
//   d    asynchronous input level
//   q    synchronized level, SYNC_STAGES edges after d
module btn_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= '0;
        else ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and classifies a raw push-button into clean events
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   btn            raw button level, asynchronous to clk
//   btn_level      debounced button level
//   press_pulse    one cycle when btn_level rises
//   release_pulse  one cycle when btn_level falls
//   long_pulse     one cycle LONG_CYCLES after press_pulse while still held
//   repeat_pulse   one cycle every REPEAT_CYCLES after long_pulse while still held
module button_conditioner
    import button_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic              btn_sync;
    logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [REP_W-1:0]  rep_cnt, rep_cnt_nxt;
    state_t            state, state_nxt;
    logic              mismatch, db_done, rise, fall;
    logic              level_nxt, press_nxt, release_nxt, long_nxt, repeat_nxt;

    btn_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (btn_sync)
    );

    // The counter must see DB_CYCLES mismatching cycles before the level is
    // accepted on the following edge, so it needs to hold DB_CYCLES itself.
    always_comb begin
        mismatch   = btn_sync != btn_level;
        db_done    = mismatch && (db_cnt == DB_W'(DB_CYCLES));
        db_cnt_nxt = (mismatch && !db_done) ? db_cnt + 1'b1 : '0;
        level_nxt  = db_done ? btn_sync : btn_level;
        rise       = db_done && btn_sync;
        fall       = db_done && !btn_sync;
    end

    // A debounced fall is checked first in every held state so it always
    // beats a long or repeat event landing on the same cycle.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        rep_cnt_nxt  = rep_cnt;
        press_nxt    = 1'b0;
        release_nxt  = 1'b0;
        long_nxt     = 1'b0;
        repeat_nxt   = 1'b0;
        case (state)
            RELEASED: begin
                if (rise) begin
                    state_nxt    = PRESSED;
                    hold_cnt_nxt = '0;
                    press_nxt    = 1'b1;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_nxt    = RELEASED;
                    hold_cnt_nxt = '0;
                    rep_cnt_nxt  = '0;
                    release_nxt  = 1'b1;
                end else if (hold_cnt == HOLD_W'(LONG_CYCLES - 1)) begin
                    state_nxt    = HELD;
                    hold_cnt_nxt = '0;
                    rep_cnt_nxt  = '0;
                    long_nxt     = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    state_nxt    = RELEASED;
                    hold_cnt_nxt = '0;
                    rep_cnt_nxt  = '0;
                    release_nxt  = 1'b1;
                end else if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
                    rep_cnt_nxt = '0;
                    repeat_nxt  = 1'b1;
                end else begin
                    rep_cnt_nxt = rep_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt    = RELEASED;
                hold_cnt_nxt = '0;
                rep_cnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RELEASED;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_nxt;
            db_cnt        <= db_cnt_nxt;
            hold_cnt      <= hold_cnt_nxt;
            rep_cnt       <= rep_cnt_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed self-checking bench for button_conditioner
//   outputs are observed as {btn_level, press, release, long, repeat}, 1 time unit after each edge
module tb_button_conditioner;

    logic clk, rst, btn;
    logic btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic [4:0] obs;
    logic [4:0] exp;
    int tests, fails;

    assign obs = {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse};

    button_conditioner #(
        .SYNC_STAGES   (2),
        .DB_CYCLES     (4),
        .LONG_CYCLES   (20),
        .REPEAT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Debounced fall from a held button: level low and release pulse on the 6th edge.
    task automatic release_and_settle(input string name);
        btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            exp = {i < 6, 1'b0, i == 6, 1'b0, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, i, obs, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        btn = 1'b0;
        repeat (3) step();
        tests++;
        if (obs !== 5'b0) begin
            fails++;
            $display("FAIL reset_held: got %b expected %b", obs, 5'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (obs !== 5'b0) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got %b expected %b", i, obs, 5'b0);
            end
        end
    endtask

    task automatic test_clean_press();
        btn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            exp = {i >= 6, i == 6, 1'b0, 1'b0, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL clean_press cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
        release_and_settle("clean_release");
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 12; i++) begin
            btn = (i / 2) % 2 == 0;
            step();
            tests++;
            if (obs !== 5'b0) begin
                fails++;
                $display("FAIL bounce cycle %0d: got %b expected %b", i, obs, 5'b0);
            end
        end
        btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            exp = {i >= 6, i == 6, 1'b0, 1'b0, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL bounce_settle cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
        release_and_settle("bounce_release");
    endtask

    task automatic test_glitch();
        btn = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) btn = 1'b0;
            step();
            tests++;
            if (obs !== 5'b0) begin
                fails++;
                $display("FAIL glitch cycle %0d: got %b expected %b", i, obs, 5'b0);
            end
        end
    endtask

    // Press at 6, long at 26, repeats at 34, 42, 50, 58, 66; btn falls at 66,
    // so the debounced fall lands at 72 and the repeat due at 74 never comes.
    task automatic test_long_repeat();
        btn = 1'b1;
        for (int i = 0; i < 66; i++) begin
            step();
            exp = {i >= 6, i == 6, 1'b0, i == 26, (i > 26) && ((i - 26) % 8 == 0)};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL long_repeat cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
        btn = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            exp = {i < 6, 1'b0, i == 6, 1'b0, i == 0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL long_release cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    // Fall starts at 20 so the debounced fall lands on 26, where long would fire.
    task automatic test_release_collision();
        btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            exp = {i >= 6, i == 6, 1'b0, 1'b0, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL collision_press cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
        btn = 1'b0;
        for (int i = 0; i < 36; i++) begin
            step();
            exp = {i < 6, 1'b0, i == 6, 1'b0, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL collision cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            exp = {i >= 6, i == 6, 1'b0, i == 26, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL hold_before_reset cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (obs !== 5'b0) begin
            fails++;
            $display("FAIL async_reset_immediate: got %b expected %b", obs, 5'b0);
        end
        repeat (2) step();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            exp = {i >= 6, i == 6, 1'b0, 1'b0, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL after_reset cycle %0d: got %b expected %b", i, obs, exp);
            end
        end
        release_and_settle("after_reset_release");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        btn = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_repeat();
        test_release_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front end for every push-button input on the board. Turns a raw, bouncing, asynchronous button level into clean, clock-synchronous events.
- Events: a debounced level, a one-cycle press pulse, a one-cycle release pulse, a long-press pulse, and auto-repeat pulses while the button is held.
- Downstream state machines (LED sequencers, mode counters) consume press_pulse directly and need no edge detection of their own.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on btn (minimum 2).
- DB_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz; minimum 1).
- LONG_CYCLES, 50000000, cycles from press_pulse to long_pulse (minimum 1).
- REPEAT_CYCLES, 10000000, cycles between successive repeat pulses after long_pulse (minimum 1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- btn  input  1  raw button level, asynchronous to clk.
- btn_level  output  1  debounced button level.
- press_pulse  output  1  one-cycle pulse when btn_level goes 0->1.
- release_pulse  output  1  one-cycle pulse when btn_level goes 1->0.
- long_pulse  output  1  one-cycle pulse after a continuous hold of LONG_CYCLES.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES after long_pulse while still held.

Behaviour:
- Reset: rst=0 asynchronously clears the synchronizer flops, all counters and all outputs to 0, and sets the state to RELEASED. All outputs are registered.
- Synchronizer: btn passes through SYNC_STAGES flops to give btn_sync.
- Debounce counter db_cnt:
  - Width is $clog2(DB_CYCLES+1).
  - Increments each cycle btn_sync != btn_level; clears to 0 on any cycle they are equal.
  - When the mismatch persists DB_CYCLES cycles, btn_level takes btn_sync at the next edge and db_cnt clears.
  - The matching press_pulse or release_pulse is asserted in the same cycle as the btn_level change.
- Latency: raw btn edge to btn_level/pulse is exactly SYNC_STAGES+DB_CYCLES rising edges. Any glitch shorter than DB_CYCLES synced cycles produces no output.
- FSM states: RELEASED, PRESSED, HELD.
  - RELEASED -> PRESSED on a debounced rise, with press_pulse. hold_cnt cleared.
  - PRESSED: hold_cnt increments each cycle. When hold_cnt reaches LONG_CYCLES-1, the next cycle asserts long_pulse, moves to HELD and clears rep_cnt. long_pulse is therefore exactly LONG_CYCLES cycles after press_pulse.
  - HELD: rep_cnt increments each cycle. When it reaches REPEAT_CYCLES-1, repeat_pulse is asserted next cycle and rep_cnt clears. Repeats continue indefinitely.
  - PRESSED or HELD -> RELEASED on a debounced fall, with release_pulse. hold_cnt and rep_cnt clear.
- Counter widths: hold_cnt is $clog2(LONG_CYCLES) bits and rep_cnt is $clog2(REPEAT_CYCLES) bits, minimum 1 bit each. No counter wraps: each clears at its terminal value.
- Simultaneous events: if a debounced fall lands on the cycle a long_pulse or repeat_pulse would fire, the release wins. release_pulse is asserted and long/repeat are suppressed.
- Mutual exclusion: at most one of press/release/long/repeat is high in any cycle.
- Reset mid-operation: after rst deasserts with btn still high, btn_level starts from 0. A fresh press_pulse follows SYNC_STAGES+DB_CYCLES edges later. No release_pulse is produced for the interrupted hold.
- No X propagation: the outputs are defined from the first clock after reset.

Decomposition:
- Shared package button_pkg holds:
  - the state encoding localparams ST_RELEASED=2'd0, ST_PRESSED=2'd1, ST_HELD=2'd2;
  - the board clock-frequency constant used to derive default cycle counts.
- One sub-module, btn_synchronizer (parameter SYNC_STAGES, ports clk, rst, d, q), holding the flop chain. Debounce and FSM stay in button_conditioner.

Test Plan:
All cases use SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8. Edge 0 is the first clk edge sampling the new btn value.
- Clean press: btn 0->1 held 15 cycles -> btn_level=1 and press_pulse=1 for exactly one cycle after edge 6; no other pulses.
- Bounce: btn toggles every 2 cycles for 12 cycles, then stays 1 -> no pulse during bounce; single press_pulse 6 edges after the last transition.
- Glitch: 3-cycle high pulse on btn from idle -> btn_level stays 0, all pulses stay 0.
- Long press and repeat: hold btn 1 for 60 cycles after press_pulse, then release.
  - long_pulse exactly 20 cycles after press_pulse.
  - repeat_pulse at +8, +16, +24 after long_pulse.
  - release_pulse 6 edges after btn falls, then no further repeats.
- Release collision: time the btn fall so the debounced fall lands on the long_pulse cycle -> release_pulse=1, long_pulse stays 0, state returns to RELEASED.
- Async reset mid-hold: drive rst=0 between clock edges while in HELD -> all outputs 0 before the next edge. Release rst with btn=1 -> press_pulse 6 edges later; no release_pulse.
